pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Fetch-side producer of the IF/ID interface: generates `if_pc` / `if_pc_plus4` for the IF/ID pipeline register.
- Obeys the same `stall` bus and `flush` that register consumes, and accepts branch/jump redirects from ID and exception redirects from the exception unit.
- Holds a redirect that arrives while the PC is stalled, so no control transfer is lost.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC value driven during and immediately after reset.
- ADDR_W, 32, instruction address width; matches `INST_ADDR_BUS`.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- stall  in  `STALL_BUS` (6)  pipeline stall vector; bit0 = PC stage, bit1 = IF, bit2 = ID.
- flush  in  1  exception flush; the same signal that clears the IF/ID register.
- exc_addr  in  ADDR_W  exception handler target, valid when flush=1.
- id_jump  in  1  ID-stage taken branch/jump.
- id_jump_addr  in  ADDR_W  branch/jump target.
- ice  out  1  instruction fetch enable.
- if_pc  out  ADDR_W  current fetch PC.
- if_pc_plus4  out  ADDR_W  `if_pc` + 4, registered.
- if_misalign  out  1  `if_pc[1:0]` != 0, registered with `if_pc`.
- redir_pending  out  1  a redirect is held awaiting stall release.

Behaviour:
- Reset (async, `cpu_rst_n`=0):
  - `if_pc` = BOOT_ADDR, `if_pc_plus4` = BOOT_ADDR+4, `ice` = 0, `if_misalign` = 0, `redir_pending` = 0.
  - Pending register cleared; state = BOOT.
  - Applies immediately, including mid-stall or mid-pending.
- States: BOOT, RUN, PEND.
- BOOT: first edge after reset release -> `ice` = 1, PC unchanged (BOOT_ADDR fetched first), go RUN. `flush`/`id_jump` ignored in BOOT.
- Next-PC priority per edge (RUN/PEND), highest first:
  1. `flush`=1: PC <= `exc_addr` regardless of `stall`; pending cleared; -> RUN.
  2. `id_jump`=1 and `stall[0]`=`STOP`: pending <= `id_jump_addr` (a later jump overwrites); PC held; -> PEND.
  3. PEND and `stall[0]`=`NOSTOP`: PC <= pending; pending cleared; -> RUN. A simultaneous `id_jump` in this same cycle wins over the pending value (younger instruction).
  4. `id_jump`=1 and `stall[0]`=`NOSTOP`: PC <= `id_jump_addr`.
  5. `stall[0]`=`NOSTOP`: PC <= PC + 4.
  6. Otherwise: hold all outputs.
- Arithmetic:
  - Addition is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
  - `if_pc_plus4` is always the registered PC + 4 (same wrap); never combinational from inputs.
- `if_misalign` is set when the loaded target has bit1 or bit0 set. The target is loaded unmodified; the exception unit acts on the flag.
- `redir_pending` = 1 exactly while in PEND.
- Latency:
  - Redirect appears on `if_pc` one edge after acceptance.
  - Sequential advance is one edge per unstalled cycle.
- Flush during PEND discards the pending target.

Decomposition:
- Shared `define.vh` supplies `INST_ADDR_BUS`, `STALL_BUS`, `STOP`, `NOSTOP`, `RST_ENABLE`, `ZERO_WORD`, plus new `PC_INC` (32'd4) and state encodings `PCG_BOOT` / `PCG_RUN` / `PCG_PEND`.
- One natural sub-module: `pc_redir_buf`, the pending-target register with set/clear/overwrite. The remainder stays flat.

Test Plan:
- Reset release, no stall, 4 cycles -> `ice` 0->1; `if_pc` 0x0, 0x0, 0x4, 0x8, 0xC; `if_pc_plus4` tracks +4.
- `stall[0]`=`STOP` for 3 cycles at PC 0x10 -> `if_pc` holds 0x10 / `if_pc_plus4` 0x14; release -> 0x14.
- Stalled at 0x20, `id_jump`=1, target 0x100 for 1 cycle -> `redir_pending`=1, PC 0x20; release -> PC 0x100, `redir_pending`=0.
- PEND with target 0x100, `flush`=1, `exc_addr`=0x380 -> PC 0x380, pending cleared; release stall -> 0x384 (not 0x100).
- PC 0xFFFF_FFF8 unstalled -> 0xFFFF_FFFC, then 0x0; `if_pc_plus4` 0x0 then 0x4.
- `id_jump` target 0x202 -> `if_pc`=0x202, `if_misalign`=1; assert `cpu_rst_n`=0 mid-cycle -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-side PC generator: stall/bus widths, stall encodings,
// PC increment and FSM state encodings.
package pc_gen_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned STALL_BUS     = 6;

  localparam logic        STOP       = 1'b1;
  localparam logic        NOSTOP     = 1'b0;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam int unsigned PC_INC = 32'd4;

  localparam logic [1:0] PCG_BOOT = 2'd0;
  localparam logic [1:0] PCG_RUN  = 2'd1;
  localparam logic [1:0] PCG_PEND = 2'd2;

endpackage

// File: rtl/pc_redir_buf.sv
// Holds a branch/jump target that arrived while the PC stage was stalled.
module pc_redir_buf #(
  parameter int unsigned AddrW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [AddrW-1:0] addr_i,
  output logic [AddrW-1:0] addr_o
);

  logic [AddrW-1:0] addr_q;

  // Clear wins over set; a repeated set simply overwrites the held target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (clr_i) begin
      addr_q <= '0;
    end else if (set_i) begin
      addr_q <= addr_i;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator for the IF/ID interface: sequential advance, ID redirects,
// exception flushes, and a held redirect while the PC stage is stalled.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = INST_ADDR_BUS,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic [STALL_BUS-1:0] stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    exc_addr,
  input  logic                 id_jump,
  input  logic [ADDR_W-1:0]    id_jump_addr,
  output logic                 ice,
  output logic [ADDR_W-1:0]    if_pc,
  output logic [ADDR_W-1:0]    if_pc_plus4,
  output logic                 if_misalign,
  output logic                 redir_pending
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic              misalign_q;
  logic              ice_q, ice_d;
  logic              pend_set, pend_clr;
  logic [ADDR_W-1:0] pend_addr;
  logic              pc_go;

  // Only the PC-stage bit of the stall bus matters here.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_BUS-1:1];

  assign pc_go = (stall[0] == NOSTOP);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ice_d    = ice_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      PCG_BOOT: begin
        ice_d   = 1'b1;
        state_d = PCG_RUN;
      end
      default: begin
        if (flush) begin
          pc_d     = exc_addr;
          pend_clr = 1'b1;
          state_d  = PCG_RUN;
        end else if (id_jump && !pc_go) begin
          pend_set = 1'b1;
          state_d  = PCG_PEND;
        end else if ((state_q == PCG_PEND) && pc_go) begin
          // A jump from a younger instruction in the same cycle beats the held target.
          pc_d     = id_jump ? id_jump_addr : pend_addr;
          pend_clr = 1'b1;
          state_d  = PCG_RUN;
        end else if (id_jump && pc_go) begin
          pc_d = id_jump_addr;
        end else if (pc_go) begin
          pc_d = pc_q + ADDR_W'(PC_INC);
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q    <= PCG_BOOT;
      pc_q       <= BOOT_ADDR;
      pc_plus4_q <= BOOT_ADDR + ADDR_W'(PC_INC);
      misalign_q <= 1'b0;
      ice_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_d + ADDR_W'(PC_INC);
      misalign_q <= |pc_d[1:0];
      ice_q      <= ice_d;
    end
  end

  pc_redir_buf #(
    .AddrW(ADDR_W)
  ) u_redir_buf (
    .clk_i (cpu_clk_50M),
    .rst_ni(cpu_rst_n),
    .set_i (pend_set),
    .clr_i (pend_clr),
    .addr_i(id_jump_addr),
    .addr_o(pend_addr)
  );

  assign ice           = ice_q;
  assign if_pc         = pc_q;
  assign if_pc_plus4   = pc_plus4_q;
  assign if_misalign   = misalign_q;
  assign redir_pending = (state_q == PCG_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle comparison against a behavioural model,
// plus directed vectors with literal expectations.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] exc_addr;
  logic        id_jump;
  logic [31:0] id_jump_addr;
  logic        ice;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_misalign;
  logic        redir_pending;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(
    .ADDR_W   (32),
    .BOOT_ADDR(32'h0000_0000)
  ) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst_n),
    .stall        (stall),
    .flush        (flush),
    .exc_addr     (exc_addr),
    .id_jump      (id_jump),
    .id_jump_addr (id_jump_addr),
    .ice          (ice),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .if_misalign  (if_misalign),
    .redir_pending(redir_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fetch PC, a one-entry held redirect, and a "started" flag.
  logic [31:0] m_pc;
  logic        m_ice;
  logic        m_pend;
  logic [31:0] m_pend_addr;

  initial begin
    m_pc = 32'h0; m_ice = 1'b0; m_pend = 1'b0; m_pend_addr = 32'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ice = 1'b0; m_pend = 1'b0; m_pend_addr = 32'h0;
    end else if (!m_ice) begin
      m_ice = 1'b1;
    end else if (flush) begin
      m_pc   = exc_addr;
      m_pend = 1'b0;
    end else if (stall[0]) begin
      if (id_jump) begin
        m_pend      = 1'b1;
        m_pend_addr = id_jump_addr;
      end
    end else begin
      if (id_jump)     m_pc = id_jump_addr;
      else if (m_pend) m_pc = m_pend_addr;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_if_pc", if_pc, m_pc);
    chk("model_if_pc_plus4", if_pc_plus4, m_pc + 32'd4);
    chk("model_if_misalign", {31'b0, if_misalign}, {31'b0, |m_pc[1:0]});
    chk("model_ice", {31'b0, ice}, {31'b0, m_ice});
    chk("model_redir_pending", {31'b0, redir_pending}, {31'b0, m_pend});
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic [31:0] pc4,
                     input logic pend);
    chk({name, "_pc"}, if_pc, pc);
    chk({name, "_pc4"}, if_pc_plus4, pc4);
    chk({name, "_pend"}, {31'b0, redir_pending}, {31'b0, pend});
  endtask

  task automatic jump(input logic en, input logic [31:0] a);
    id_jump      = en;
    id_jump_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 6'b0; flush = 1'b0; exc_addr = 32'h0;
    id_jump = 1'b0; id_jump_addr = 32'h0;
    cyc(); cyc();
    lit("reset", 32'h0, 32'h4, 1'b0);
    chk("reset_ice", {31'b0, ice}, 32'h0);
    rst_n = 1'b1;

    // Boot: BOOT_ADDR fetched first, then sequential advance.
    cyc(); lit("boot0", 32'h0, 32'h4, 1'b0);
    chk("boot_ice", {31'b0, ice}, 32'h1);
    cyc(); lit("seq4", 32'h4, 32'h8, 1'b0);
    cyc(); lit("seq8", 32'h8, 32'hC, 1'b0);
    cyc(); lit("seqC", 32'hC, 32'h10, 1'b0);
    cyc(); lit("seq10", 32'h10, 32'h14, 1'b0);

    // Plain stall holds the PC.
    stall = 6'b000001;
    cyc(); cyc(); cyc(); lit("stall_hold", 32'h10, 32'h14, 1'b0);
    stall = 6'b0;
    cyc(); lit("stall_rel", 32'h14, 32'h18, 1'b0);
    cyc(); cyc(); cyc(); lit("at20", 32'h20, 32'h24, 1'b0);

    // Jump while stalled is held, then taken on release.
    stall = 6'b000001; jump(1'b1, 32'h100);
    cyc(); lit("pend_set", 32'h20, 32'h24, 1'b1);
    jump(1'b0, 32'h0);
    cyc(); lit("pend_hold", 32'h20, 32'h24, 1'b1);
    stall = 6'b0;
    cyc(); lit("pend_take", 32'h100, 32'h104, 1'b0);

    // Flush during PEND discards the held target.
    stall = 6'b000001; jump(1'b1, 32'h100);
    cyc(); lit("pend2", 32'h100, 32'h104, 1'b1);
    jump(1'b0, 32'h0); flush = 1'b1; exc_addr = 32'h380;
    cyc(); lit("flush", 32'h380, 32'h384, 1'b0);
    flush = 1'b0;
    cyc(); lit("flush_stall", 32'h380, 32'h384, 1'b0);
    stall = 6'b0;
    cyc(); lit("flush_rel", 32'h384, 32'h388, 1'b0);

    // Address wrap-around.
    jump(1'b1, 32'hFFFF_FFF8);
    cyc(); lit("wrap_a", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0);
    jump(1'b0, 32'h0);
    cyc(); lit("wrap_b", 32'hFFFF_FFFC, 32'h0, 1'b0);
    cyc(); lit("wrap_c", 32'h0, 32'h4, 1'b0);

    // Jump on the release cycle beats the held target.
    stall = 6'b000001; jump(1'b1, 32'h40);
    cyc(); lit("young_pend", 32'h0, 32'h4, 1'b1);
    stall = 6'b0; jump(1'b1, 32'h80);
    cyc(); lit("young_wins", 32'h80, 32'h84, 1'b0);

    // A later stalled jump overwrites the held target.
    stall = 6'b000001; jump(1'b1, 32'h200);
    cyc(); jump(1'b1, 32'h300);
    cyc(); lit("overwrite", 32'h80, 32'h84, 1'b1);
    stall = 6'b0; jump(1'b0, 32'h0);
    cyc(); lit("overwrite_take", 32'h300, 32'h304, 1'b0);

    // Misaligned target is loaded unmodified and flagged.
    jump(1'b1, 32'h202);
    cyc(); lit("misalign", 32'h202, 32'h206, 1'b0);
    chk("misalign_flag", {31'b0, if_misalign}, 32'h1);

    // Asynchronous reset mid-cycle while a redirect is pending.
    stall = 6'b000001; jump(1'b1, 32'h500);
    cyc(); lit("pre_rst_pend", 32'h202, 32'h206, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst", 32'h0, 32'h4, 1'b0);
    chk("async_rst_ice", {31'b0, ice}, 32'h0);
    chk("async_rst_mis", {31'b0, if_misalign}, 32'h0);
    stall = 6'b0; jump(1'b0, 32'h0);
    cyc(); rst_n = 1'b1;
    cyc(); lit("reboot", 32'h0, 32'h4, 1'b0);
    chk("reboot_ice", {31'b0, ice}, 32'h1);
    cyc(); lit("reboot_seq", 32'h4, 32'h8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
